dpram_arbiter: RTL and testbench

- Shares the single write port and single read port of the 256x16 dual-port RAM between two requesters (0 and 1).
- Each port has its own round-robin arbiter and a valid/grant handshake.
- Read responses are routed back to the issuing requester after the RAM read latency.
- Read-after-write ordering to the same address is enforced by stalling the read grant.

---
 rtl/dpram_arbiter.sv | 100 ++++++++++
 tb/tb_dpram_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Two-requester arbiter for the single write port and single read port of a dual-port RAM.
// Round-robin per port, RAW stall on the read grant, and tagged read-response routing.
module dpram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        rd_cand;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_data_sel;
  logic [ADDR_W-1:0] r_addr_sel;
  logic              raw_hazard;
  logic [RD_LAT:0]   tag_v;
  logic [RD_LAT:0]   tag_id;

  // Pointer value 0 favours requester 0; it only moves when both ports contend.
  always_comb begin
    wr_gnt = 2'b00;
    unique case (wr_req)
      2'b01:   wr_gnt = 2'b01;
      2'b10:   wr_gnt = 2'b10;
      2'b11:   wr_gnt = wr_ptr ? 2'b10 : 2'b01;
      default: wr_gnt = 2'b00;
    endcase
  end

  always_comb begin
    rd_cand = 2'b00;
    unique case (rd_req)
      2'b01:   rd_cand = 2'b01;
      2'b10:   rd_cand = 2'b10;
      2'b11:   rd_cand = rd_ptr ? 2'b10 : 2'b01;
      default: rd_cand = 2'b00;
    endcase
  end

  assign w_addr_sel = wr_gnt[1] ? wr_addr1 : wr_addr0;
  assign w_data_sel = wr_gnt[1] ? wr_data1 : wr_data0;
  assign r_addr_sel = rd_cand[1] ? rd_addr1 : rd_addr0;

  // A read must not overtake a write to the same address still on its way into the RAM.
  assign raw_hazard = ((|wr_gnt) && (w_addr_sel == r_addr_sel)) ||
                      (ram_wr && (ram_w_addr == r_addr_sel));
  assign rd_gnt     = raw_hazard ? 2'b00 : rd_cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      ram_wr     <= 1'b0;
      ram_w_addr <= '0;
      ram_din    <= '0;
      ram_r_addr <= '0;
      tag_v      <= '0;
      tag_id     <= '0;
    end else begin
      ram_wr <= |wr_gnt;
      if (|wr_gnt) begin
        ram_w_addr <= w_addr_sel;
        ram_din    <= w_data_sel;
      end
      if (&wr_req) wr_ptr <= ~wr_ptr;
      if (|rd_gnt) ram_r_addr <= r_addr_sel;
      if ((&rd_req) && (|rd_gnt)) rd_ptr <= ~rd_ptr;
      tag_v[0]  <= |rd_gnt;
      tag_id[0] <= rd_gnt[1];
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rd_rvalid = {tag_v[RD_LAT] & tag_id[RD_LAT], tag_v[RD_LAT] & ~tag_id[RD_LAT]};
  assign rd_rdata  = (|rd_rvalid) ? ram_dout : '0;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (grant rules, shadow memory, expected-response queue).
module tb_dpram_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_req;
  logic [7:0]  wr_addr0, wr_addr1;
  logic [15:0] wr_data0, wr_data1;
  logic [1:0]  wr_gnt;
  logic [1:0]  rd_req;
  logic [7:0]  rd_addr0, rd_addr1;
  logic [1:0]  rd_gnt;
  logic [1:0]  rd_rvalid;
  logic [15:0] rd_rdata;
  logic [7:0]  ram_w_addr;
  logic        ram_wr;
  logic [15:0] ram_din;
  logic [7:0]  ram_r_addr;
  logic [15:0] ram_dout;

  int checks = 0;
  int errors = 0;

  dpram_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .ram_w_addr(ram_w_addr), .ram_wr(ram_wr), .ram_din(ram_din),
    .ram_r_addr(ram_r_addr), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256x16 RAM with one cycle of registered read latency
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_w_addr] <= ram_din;
    ram_dout <= mem[ram_r_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_req = 2'b00; rd_req = 2'b00;
    wr_addr0 = 8'h00; wr_addr1 = 8'h00; rd_addr0 = 8'h00; rd_addr1 = 8'h00;
    wr_data0 = 16'h0000; wr_data1 = 16'h0000;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || ram_w_addr !== 8'h00 || ram_din !== 16'h0000 || ram_r_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_ram: got wr=%b waddr=%h din=%h raddr=%h expected 0/00/0000/00",
               ram_wr, ram_w_addr, ram_din, ram_r_addr);
    end
    checks++;
    if (rd_rvalid !== 2'b00 || rd_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rd: got rvalid=%b rdata=%h expected 00/0000", rd_rvalid, rd_rdata);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    wr_req = 2'b01; wr_addr0 = 8'h05; wr_data0 = 16'hCAFE;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01) begin errors++; $display("FAIL tp1_wr_gnt: got %b expected 01", wr_gnt); end
    tick();
    wr_req = 2'b00;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b1 || ram_w_addr !== 8'h05 || ram_din !== 16'hCAFE) begin
      errors++;
      $display("FAIL tp1_issue: got wr=%b addr=%h din=%h expected 1/05/cafe", ram_wr, ram_w_addr, ram_din);
    end
    tick();
    rd_req = 2'b01; rd_addr0 = 8'h05;
    @(negedge clk);
    checks++;
    if (ram_wr !== 1'b0 || ram_w_addr !== 8'h05 || ram_din !== 16'hCAFE) begin
      errors++;
      $display("FAIL tp1_hold: got wr=%b addr=%h din=%h expected 0/05/cafe", ram_wr, ram_w_addr, ram_din);
    end
    checks++;
    if (rd_gnt !== 2'b01) begin errors++; $display("FAIL tp1_rd_gnt: got %b expected 01", rd_gnt); end
    tick();
    rd_req = 2'b00;
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b00 || ram_r_addr !== 8'h05) begin
      errors++;
      $display("FAIL tp1_early: got rvalid=%b raddr=%h expected 00/05", rd_rvalid, ram_r_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b01 || rd_rdata !== 16'hCAFE) begin
      errors++;
      $display("FAIL tp1_resp: got rvalid=%b rdata=%h expected 01/cafe", rd_rvalid, rd_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b00) begin errors++; $display("FAIL tp1_pulse: got %b expected 00", rd_rvalid); end
    tick();
  endtask

  task automatic test_write_rr();
    logic [1:0] exp_g;
    logic [7:0] prev_a;
    logic [15:0] prev_d;
    wr_req = 2'b11;
    wr_addr0 = 8'h10; wr_data0 = 16'hA010;
    wr_addr1 = 8'h20; wr_data1 = 16'hB020;
    prev_a = 8'h00; prev_d = 16'h0000;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) wr_req = 2'b00;
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (ram_wr !== 1'b1 || ram_w_addr !== prev_a || ram_din !== prev_d) begin
          errors++;
          $display("FAIL tp2_ram k=%0d: got wr=%b addr=%h din=%h expected 1/%h/%h",
                   k, ram_wr, ram_w_addr, ram_din, prev_a, prev_d);
        end
      end
      if (k < 4) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (wr_gnt !== exp_g) begin
          errors++;
          $display("FAIL tp2_wr_gnt k=%0d: got %b expected %b", k, wr_gnt, exp_g);
        end
        prev_a = (k % 2 == 0) ? 8'h10 : 8'h20;
        prev_d = (k % 2 == 0) ? 16'hA010 : 16'hB020;
      end
      tick();
    end
  endtask

  task automatic test_raw();
    wr_req = 2'b01; wr_addr0 = 8'h33; wr_data0 = 16'hBEEF;
    rd_req = 2'b10; rd_addr1 = 8'h33;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b00) begin
      errors++;
      $display("FAIL tp3_stall0: got wr_gnt=%b rd_gnt=%b expected 01/00", wr_gnt, rd_gnt);
    end
    tick();
    wr_req = 2'b00;
    @(negedge clk);
    checks++;
    if (rd_gnt !== 2'b00) begin errors++; $display("FAIL tp3_stall1: got %b expected 00", rd_gnt); end
    tick();
    @(negedge clk);
    checks++;
    if (rd_gnt !== 2'b10) begin errors++; $display("FAIL tp3_grant: got %b expected 10", rd_gnt); end
    tick();
    rd_req = 2'b00;
    tick();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b10 || rd_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL tp3_resp: got rvalid=%b rdata=%h expected 10/beef", rd_rvalid, rd_rdata);
    end
    tick();
    // different addresses: both ports granted together
    wr_req = 2'b10; wr_addr1 = 8'h40; wr_data1 = 16'h4040;
    rd_req = 2'b01; rd_addr0 = 8'h41;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b10 || rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL concurrent: got wr_gnt=%b rd_gnt=%b expected 10/01", wr_gnt, rd_gnt);
    end
    tick();
    wr_req = 2'b00; rd_req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [15:0] exp_d;
    for (int i = 1; i <= 4; i++) begin
      wr_req = 2'b01; wr_addr0 = 8'(i); wr_data0 = 16'(i * 16'h1111);
      tick();
    end
    wr_req = 2'b00;
    tick(); tick();
    rd_req = 2'b11; rd_addr0 = 8'h01; rd_addr1 = 8'h02;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (rd_gnt !== exp_g) begin
          errors++;
          $display("FAIL tp4_rd_gnt k=%0d: got %b expected %b", k, rd_gnt, exp_g);
        end
      end
      if (k >= 2 && k < 6) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        exp_d = 16'((k - 1) * 16'h1111);
        checks++;
        if (rd_rvalid !== exp_g || rd_rdata !== exp_d) begin
          errors++;
          $display("FAIL tp4_resp k=%0d: got rvalid=%b rdata=%h expected %b/%h",
                   k, rd_rvalid, rd_rdata, exp_g, exp_d);
        end
      end
      if (k == 6) begin
        checks++;
        if (rd_rvalid !== 2'b00) begin errors++; $display("FAIL tp4_tail: got %b expected 00", rd_rvalid); end
      end
      tick();
      case (k)
        0: rd_addr0 = 8'h03;
        1: rd_addr1 = 8'h04;
        2: rd_req = 2'b10;
        3: rd_req = 2'b00;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset_mid();
    // leave both pointers favouring requester 1 before the reset
    wr_req = 2'b11; wr_addr0 = 8'h06; wr_data0 = 16'h1234; wr_addr1 = 8'h08; wr_data1 = 16'h5678;
    rd_req = 2'b01; rd_addr0 = 8'h05;
    @(negedge clk);
    checks++;
    if (rd_gnt !== 2'b01 || wr_gnt !== 2'b01) begin
      errors++;
      $display("FAIL tp5_pre: got rd_gnt=%b wr_gnt=%b expected 01/01", rd_gnt, wr_gnt);
    end
    tick();
    wr_req = 2'b00; rd_req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ram_wr !== 1'b0 || rd_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL tp5_async: got ram_wr=%b rvalid=%b expected 0/00", ram_wr, rd_rvalid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b00) begin errors++; $display("FAIL tp5_late0: got %b expected 00", rd_rvalid); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_rvalid !== 2'b00 || ram_wr !== 1'b0) begin
      errors++;
      $display("FAIL tp5_late1: got rvalid=%b ram_wr=%b expected 00/0", rd_rvalid, ram_wr);
    end
    tick();
    wr_req = 2'b11; wr_addr0 = 8'h0A; wr_addr1 = 8'h0B;
    rd_req = 2'b11; rd_addr0 = 8'h09; rd_addr1 = 8'h0C;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      errors++;
      $display("FAIL tp5_ptr: got wr_gnt=%b rd_gnt=%b expected 01/01", wr_gnt, rd_gnt);
    end
    tick();
    wr_req = 2'b00; rd_req = 2'b00;
    tick(); tick(); tick();
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    a = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic test_random(input int n);
    bit [15:0] shadow [256];
    bit        known [256];
    int        due_q [$];
    int        id_q [$];
    bit [15:0] dat_q [$];
    bit        kn_q [$];
    int        fav_w, fav_r, wi, ri, cyc;
    bit        lw_v, w_both, r_both;
    bit [7:0]  lw_a, wa, ra;
    bit [15:0] lw_d, wd;
    logic [1:0] ewg, erg, erv;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    wr_req = 2'b00; rd_req = 2'b00;
    @(negedge clk); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    fav_w = 0; fav_r = 0; lw_v = 1'b0; lw_a = 8'h00; lw_d = 16'h0000; cyc = 0;
    for (int k = 0; k < n + 6; k++) begin
      if (k < n) begin
        if (!wr_req[0] && $urandom_range(0, 2) != 0) begin
          wr_req[0] = 1'b1; wr_addr0 = rand_addr(); wr_data0 = 16'($urandom);
        end
        if (!wr_req[1] && $urandom_range(0, 2) != 0) begin
          wr_req[1] = 1'b1; wr_addr1 = rand_addr(); wr_data1 = 16'($urandom);
        end
        if (!rd_req[0] && $urandom_range(0, 2) != 0) begin rd_req[0] = 1'b1; rd_addr0 = rand_addr(); end
        if (!rd_req[1] && $urandom_range(0, 2) != 0) begin rd_req[1] = 1'b1; rd_addr1 = rand_addr(); end
      end
      @(negedge clk);
      w_both = (wr_req == 2'b11);
      r_both = (rd_req == 2'b11);
      wi = w_both ? fav_w : (wr_req[0] ? 0 : (wr_req[1] ? 1 : -1));
      ri = r_both ? fav_r : (rd_req[0] ? 0 : (rd_req[1] ? 1 : -1));
      wa = (wi == 1) ? wr_addr1 : wr_addr0;
      wd = (wi == 1) ? wr_data1 : wr_data0;
      ra = (ri == 1) ? rd_addr1 : rd_addr0;
      if (ri >= 0 && ((wi >= 0 && wa == ra) || (lw_v && lw_a == ra))) ri = -1;
      ewg = (wi < 0) ? 2'b00 : ((wi == 0) ? 2'b01 : 2'b10);
      erg = (ri < 0) ? 2'b00 : ((ri == 0) ? 2'b01 : 2'b10);
      checks++;
      if (wr_gnt !== ewg || rd_gnt !== erg) begin
        errors++;
        $display("FAIL rand_gnt cyc=%0d: got wr=%b rd=%b expected wr=%b rd=%b", cyc, wr_gnt, rd_gnt, ewg, erg);
      end
      checks++;
      if (ram_wr !== lw_v || (lw_v && (ram_w_addr !== lw_a || ram_din !== lw_d))) begin
        errors++;
        $display("FAIL rand_wport cyc=%0d: got wr=%b addr=%h din=%h expected %b/%h/%h",
                 cyc, ram_wr, ram_w_addr, ram_din, lw_v, lw_a, lw_d);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        erv = (id_q[0] == 0) ? 2'b01 : 2'b10;
        checks++;
        if (rd_rvalid !== erv || (kn_q[0] && rd_rdata !== dat_q[0])) begin
          errors++;
          $display("FAIL rand_resp cyc=%0d: got rvalid=%b rdata=%h expected %b/%h",
                   cyc, rd_rvalid, rd_rdata, erv, dat_q[0]);
        end
        void'(due_q.pop_front()); void'(id_q.pop_front());
        void'(dat_q.pop_front()); void'(kn_q.pop_front());
      end else begin
        checks++;
        if (rd_rvalid !== 2'b00) begin
          errors++;
          $display("FAIL rand_idle cyc=%0d: got rvalid=%b expected 00", cyc, rd_rvalid);
        end
      end
      tick();
      if (ri >= 0) begin
        due_q.push_back(cyc + 2); id_q.push_back(ri);
        dat_q.push_back(shadow[ra]); kn_q.push_back(known[ra]);
        if (r_both) fav_r = 1 - ri;
        rd_req[ri] = 1'b0;
      end
      if (wi >= 0) begin
        shadow[wa] = wd; known[wa] = 1'b1;
        if (w_both) fav_w = 1 - wi;
        wr_req[wi] = 1'b0;
        lw_v = 1'b1; lw_a = wa; lw_d = wd;
      end else begin
        lw_v = 1'b0;
      end
      cyc++;
    end
    wr_req = 2'b00; rd_req = 2'b00;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_rr();
    test_raw();
    test_back_to_back();
    test_reset_mid();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
